// File: rtl/imem_line_responder.sv
// Instruction-fetch responder backed by a single-line buffer.
// Misses refill the whole line with a fixed-length burst from the backing bus.
module imem_line_responder #(
  parameter int BMEM_W = 64,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       imem_addr,
  input  logic [3:0]        imem_rmask,
  input  logic              imem_invalidate,
  output logic [31:0]       imem_rdata,
  output logic              imem_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  input  logic              bmem_ready,
  input  logic [BMEM_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);
  localparam int LINE_BITS = BMEM_W * BEATS;
  localparam int OFF_W     = $clog2(LINE_BITS / 8);
  localparam int WORDS     = LINE_BITS / 32;
  localparam int TAG_W     = 32 - OFF_W;
  localparam int BEAT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_e;
  state_e state_q, state_d;

  logic [BEATS-1:0][BMEM_W-1:0] line_q, line_fill;
  logic [WORDS-1:0][31:0]       line_words, fill_words;
  logic [TAG_W-1:0]             tag_q;
  logic [31:2]                  addr_q;
  logic [BEAT_W-1:0]            beat_q;
  logic                         valid_q, inv_pend_q;
  logic                         req, hit, miss, beat_in, last_beat;
  logic                         unused_addr_lo;

  assign unused_addr_lo = ^imem_addr[1:0];

  assign req       = |imem_rmask;
  assign hit       = (state_q == IDLE) && req && valid_q && !imem_invalidate &&
                     (tag_q == imem_addr[31:OFF_W]);
  assign miss      = (state_q == IDLE) && req && !hit;
  assign beat_in   = (state_q == FILL) && bmem_rvalid;
  assign last_beat = beat_in && (beat_q == BEAT_W'(BEATS - 1));
  assign bmem_read = (state_q == FETCH);

  // Line image with the incoming beat merged, so the final response can
  // come from the completed line in the same cycle the last beat lands.
  always_comb begin
    line_fill         = line_q;
    line_fill[beat_q] = bmem_rdata;
  end

  assign line_words = line_q;
  assign fill_words = line_fill;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss)       state_d = FETCH;
      FETCH:   if (bmem_ready) state_d = FILL;
      FILL:    if (last_beat)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      inv_pend_q <= 1'b0;
      beat_q     <= '0;
      addr_q     <= '0;
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      bmem_addr  <= '0;
    end else begin
      imem_resp <= 1'b0;
      if (hit) begin
        imem_resp  <= 1'b1;
        imem_rdata <= line_words[imem_addr[OFF_W-1:2]];
      end
      if (miss) begin
        addr_q     <= imem_addr[31:2];
        bmem_addr  <= {imem_addr[31:OFF_W], {OFF_W{1'b0}}};
        valid_q    <= 1'b0;
        inv_pend_q <= 1'b0;
      end
      if ((state_q == IDLE) && imem_invalidate) valid_q <= 1'b0;
      // An invalidate while the fill is in flight must outlive the fill.
      if ((state_q != IDLE) && imem_invalidate) inv_pend_q <= 1'b1;
      if ((state_q == FETCH) && bmem_ready) beat_q <= '0;
      if (beat_in) beat_q <= beat_q + BEAT_W'(1);
      if (last_beat) begin
        valid_q    <= !(inv_pend_q || imem_invalidate);
        imem_resp  <= 1'b1;
        imem_rdata <= fill_words[addr_q[OFF_W-1:2]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_in)   line_q <= line_fill;
    if (last_beat) tag_q  <= addr_q[31:OFF_W];
  end

  a_no_req_busy: assert property (@(posedge clk) disable iff (!rst)
    (state_q != IDLE) |-> !req);

endmodule

// File: tb/tb_imem_line_responder.sv
// Scoreboard bench for imem_line_responder: directed fetches, fills, invalidates, reset.
module tb_imem_line_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [3:0]  imem_rmask = '0;
  logic        imem_invalidate = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready = 1'b0;
  logic [63:0] bmem_rdata = '0;
  logic        bmem_rvalid = 1'b0;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int exp_acc = 0;
  logic [31:0] sb[$];

  imem_line_responder #(.BMEM_W(64), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_invalidate(imem_invalidate),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bmem_read && bmem_ready) acc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Word i of a line filled with a given salt; salt 0 gives i*0x11111111.
  function automatic logic [31:0] wval(input logic [31:0] salt, input int i);
    return (32'(i) * 32'h1111_1111) ^ salt;
  endfunction

  function automatic logic [63:0] beat(input logic [31:0] salt, input int k);
    return {wval(salt, 2*k+1), wval(salt, 2*k)};
  endfunction

  // Monitor: every response must match the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (imem_resp) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got rdata %h, required no response", imem_rdata);
      end else begin
        chk("resp_rdata", imem_rdata, sb.pop_front());
      end
    end
  end

  task automatic drive_req(input logic [31:0] a);
    @(negedge clk);
    imem_addr  = a;
    imem_rmask = 4'hF;
  endtask

  task automatic end_req();
    @(negedge clk);
    imem_rmask = 4'h0;
  endtask

  task automatic wait_read(input logic [31:0] base, output bit ok);
    for (int i = 0; i < 10 && !bmem_read; i++) @(negedge clk);
    chk("bmem_read_seen", {31'b0, bmem_read}, 32'h1);
    ok = bmem_read;
    if (ok) chk("bmem_addr", bmem_addr, base);
  endtask

  task automatic do_fill(input logic [31:0] base, input logic [31:0] salt,
                         input int delay, input bit inv_mid);
    bit ok;
    wait_read(base, ok);
    if (!ok) return;
    exp_acc++;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("read_held", {31'b0, bmem_read}, 32'h1);
      chk("addr_stable", bmem_addr, base);
    end
    bmem_ready = 1'b1;
    @(negedge clk);
    bmem_ready = 1'b0;
    chk("read_dropped", {31'b0, bmem_read}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid     = 1'b1;
      bmem_rdata      = beat(salt, k);
      imem_invalidate = inv_mid && (k == 1);
      @(negedge clk);
    end
    bmem_rvalid     = 1'b0;
    imem_invalidate = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("accept_count", 32'(acc_cnt), 32'(exp_acc));
  endtask

  task automatic miss_req(input logic [31:0] a, input logic [31:0] salt, input int delay,
                          input bit inv_mid);
    sb.push_back(wval(salt, int'(a[4:2])));
    drive_req(a);
    end_req();
    do_fill({a[31:5], 5'b0}, salt, delay, inv_mid);
  endtask

  task automatic hit_done();
    @(negedge clk);
    @(negedge clk);
    chk("hit_drained", 32'(sb.size()), 32'h0);
    chk("hit_no_read", {31'b0, bmem_read}, 32'h0);
    chk("hit_no_accept", 32'(acc_cnt), 32'(exp_acc));
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_resp", {31'b0, imem_resp}, 32'h0);
    chk("rst_rdata", imem_rdata, 32'h0);
    chk("rst_read", {31'b0, bmem_read}, 32'h0);
    chk("rst_baddr", bmem_addr, 32'h0);
    rst = 1'b1;

    // Cold miss at 0x1004.
    miss_req(32'h1004, 32'h0, 0, 1'b0);

    // Back-to-back hits.
    sb.push_back(32'h0000_0000); drive_req(32'h1000);
    sb.push_back(32'h7777_7777); drive_req(32'h101C);
    sb.push_back(32'h2222_2222); drive_req(32'h1008);
    end_req();
    hit_done();

    // Backpressured fetch for another line.
    miss_req(32'h1044, 32'h4040_4040, 5, 1'b0);

    // Restore 0x1000, hit it, invalidate in IDLE, then it must miss.
    miss_req(32'h1004, 32'h0, 0, 1'b0);
    sb.push_back(32'h3333_3333); drive_req(32'h100C); end_req();
    hit_done();
    @(negedge clk); imem_invalidate = 1'b1;
    @(negedge clk); imem_invalidate = 1'b0;
    miss_req(32'h1004, 32'h0, 0, 1'b1);
    miss_req(32'h1010, 32'h0, 0, 1'b0);
    sb.push_back(32'h6666_6666); drive_req(32'h1018); end_req();
    hit_done();

    // Reset mid-fill: no response, outputs back to reset values, stray beats ignored.
    drive_req(32'h2000);
    end_req();
    wait_read(32'h2000, ok);
    if (ok) begin
      exp_acc++;
      bmem_ready = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
        bmem_rvalid = 1'b1; bmem_rdata = beat(32'h2020_2020, k);
        @(negedge clk);
      end
      bmem_rvalid = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_resp", {31'b0, imem_resp}, 32'h0);
    chk("mid_rst_rdata", imem_rdata, 32'h0);
    chk("mid_rst_read", {31'b0, bmem_read}, 32'h0);
    chk("mid_rst_baddr", bmem_addr, 32'h0);
    for (int k = 2; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = beat(32'h2020_2020, k);
      @(negedge clk);
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_no_read", {31'b0, bmem_read}, 32'h0);
    miss_req(32'h2008, 32'h2020_2020, 0, 1'b0);

    // Line replacement: 0x1000 resident, 0x1020 evicts it.
    miss_req(32'h1000, 32'h0, 0, 1'b0);
    miss_req(32'h1020, 32'hA5A5_A5A5, 0, 1'b0);
    sb.push_back(32'hB4B4_B4B4); drive_req(32'h1024); end_req();
    hit_done();
    miss_req(32'h1000, 32'h0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
